shift_mc: RTL and testbench

Multi-cycle shift/rotate unit for the ALU2 path. Generalises the fixed 3-bit-per-cycle shifter in four ways: width and step sizes are parameters, a coarse bypass step shortens long shifts, rotates are supported, and a ready/done handshake with flush lets the issue stage abort on pipeline flush. Operands are captured on `start`. The result is produced after a bounded number of cycles, which depends only on the shift amount.

---
 rtl/shift_mc.sv | 138 +++++++++++++
 tb/tb_shift_mc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_mc.sv
// Multi-cycle shift/rotate unit: coarse bypass steps plus fine steps, with
// ready/done handshake and synchronous flush.
module shift_mc #(
    parameter int XLEN                = 32,
    parameter int MAX_SHIFT_PER_CYCLE = 3,
    parameter int COARSE_STEP         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [XLEN-1:0]          data_in,
    input  logic [$clog2(XLEN)-1:0]  shift_amount,
    input  logic                     flush,
    output logic                     ready,
    output logic [XLEN-1:0]          data_out,
    output logic                     done
);

    localparam int            SW        = $clog2(XLEN);
    localparam logic [SW-1:0] FINE_STEP = SW'(MAX_SHIFT_PER_CYCLE);
    localparam logic [SW-1:0] COARSE    = SW'(COARSE_STEP);
    localparam bit            COARSE_EN = (COARSE_STEP > 0);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   val_q, val_d;
    logic [SW-1:0]     rem_q, rem_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   data_out_q, data_out_d;
    logic              done_q, done_d;
    logic [SW-1:0]     step_s;
    logic [XLEN-1:0]   shifted_s;

    // Rotates use a doubled word so no out-of-range shift amount is ever needed.
    function automatic logic [XLEN-1:0] shift_step(
        input logic [XLEN-1:0] val,
        input logic [2:0]      op_v,
        input logic [SW-1:0]   amt
    );
        logic [2*XLEN-1:0] dbl;
        logic [XLEN-1:0]   res;
        dbl = {val, val};
        case (op_v)
            OP_SLL:  res = val << amt;
            OP_SRL:  res = val >> amt;
            OP_SRA:  res = $signed(val) >>> amt;
            OP_ROL:  begin dbl = dbl << amt; res = dbl[2*XLEN-1:XLEN]; end
            OP_ROR:  begin dbl = dbl >> amt; res = dbl[XLEN-1:0]; end
            default: res = val;
        endcase
        return res;
    endfunction

    // Step selection: pass-through finishes at once, else coarse then fine.
    always_comb begin
        step_s = FINE_STEP;
        if (op_q > OP_ROR) begin
            step_s = rem_q;
        end else if (COARSE_EN && (rem_q >= COARSE)) begin
            step_s = COARSE;
        end else if (rem_q < FINE_STEP) begin
            step_s = rem_q;
        end else begin
            step_s = FINE_STEP;
        end
        shifted_s = shift_step(val_q, op_q, step_s);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        rem_d      = rem_q;
        op_d       = op_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    val_d   = data_in;
                    rem_d   = shift_amount;
                    op_d    = op;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (step_s == rem_q) begin
                    data_out_d = shifted_s;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    val_d = shifted_s;
                    rem_d = rem_q - step_s;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            val_q      <= '0;
            rem_q      <= '0;
            op_q       <= 3'b000;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            rem_q      <= rem_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign data_out = data_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_mc.sv
// Directed scoreboard bench for shift_mc (default build plus a build without
// the coarse bypass).
module tb_shift_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start_c;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shift_amount;
    logic        flush;
    logic        ready, done, ready_c, done_c;
    logic [31:0] data_out, data_out_c;

    always #5 clk = ~clk;

    shift_mc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
        .shift_amount(shift_amount), .flush(flush), .ready(ready),
        .data_out(data_out), .done(done)
    );

    shift_mc #(.XLEN(32), .MAX_SHIFT_PER_CYCLE(3), .COARSE_STEP(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .op(op), .data_in(data_in),
        .shift_amount(shift_amount), .flush(flush), .ready(ready_c),
        .data_out(data_out_c), .done(done_c)
    );

    typedef struct {
        logic [31:0] data;
        int          n;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_out;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op_v, input logic [31:0] d_v, input logic [4:0] a_v);
        op = op_v; data_in = d_v; shift_amount = a_v; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("ready_fall", {63'd0, ready}, 64'd0);
    endtask

    // Waits for done, optionally pulsing a foreign start at RUN cycle 'poke'.
    task automatic wait_done(input int poke);
        int   edges = 0;
        bit   seen = 1'b0;
        bit   rdy_ok = 1'b1;
        exp_t e;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            start = 1'b0;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (ready !== 1'b0) rdy_ok = 1'b0;
            if (edges == poke) begin
                start = 1'b1; data_in = 32'hDEAD_BEEF; op = 3'b001; shift_amount = 5'd5;
            end
        end
        e = sb_q.pop_front();
        check({e.tag, "_done"},   {63'd0, seen}, 64'd1);
        check({e.tag, "_cycles"}, 64'(edges), 64'(e.n));
        check({e.tag, "_data"},   {32'd0, data_out}, {32'd0, e.data});
        check({e.tag, "_ready_hi"}, {63'd0, ready}, 64'd1);
        check({e.tag, "_ready_lo"}, {63'd0, rdy_ok}, 64'd1);
        last_out = e.data;
    endtask

    task automatic run(input string tag, input logic [2:0] op_v, input logic [31:0] d_v,
                       input logic [4:0] a_v, input logic [31:0] exp_v, input int n_v,
                       input int poke);
        exp_t e;
        e.data = exp_v; e.n = n_v; e.tag = tag;
        sb_q.push_back(e);
        issue(op_v, d_v, a_v);
        wait_done(poke);
    endtask

    // Flush sampled on the k-th edge after capture.
    task automatic flush_test(input string tag, input logic [2:0] op_v, input logic [31:0] d_v,
                              input logic [4:0] a_v, input int k);
        issue(op_v, d_v, a_v);
        for (int i = 1; i < k; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_nodone_pre"}, {63'd0, done}, 64'd0);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check({tag, "_nodone"}, {63'd0, done}, 64'd0);
        check({tag, "_ready"},  {63'd0, ready}, 64'd1);
        check({tag, "_hold"},   {32'd0, data_out}, {32'd0, last_out});
        @(posedge clk);
        @(negedge clk);
        check({tag, "_nodone_post"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int   edges;
        bit   seen;
        rst_n = 1'b0; start = 1'b0; start_c = 1'b0; flush = 1'b0;
        op = 3'b000; data_in = 32'd0; shift_amount = 5'd0; last_out = 32'd0;
        #2;
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_done",  {63'd0, done}, 64'd0);
        check("rst_data",  {32'd0, data_out}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("sll31",  3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 6, 0);
        run("sra4",   3'b010, 32'h8000_0000, 5'd4,  32'hF800_0000, 2, 0);
        run("srl4",   3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000, 2, 0);
        run("ror8",   3'b100, 32'h0000_00F1, 5'd8,  32'hF100_0000, 1, 0);
        run("rol1",   3'b011, 32'h8000_0001, 5'd1,  32'h0000_0003, 1, 0);
        run("srl0",   3'b001, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, 0);
        run("pass",   3'b111, 32'hCAFE_BABE, 5'd20, 32'hCAFE_BABE, 1, 0);
        run("sra12",  3'b010, 32'h7000_0000, 5'd12, 32'h0007_0000, 3, 0);

        flush_test("flush_mid", 3'b000, 32'h0000_0005, 5'd20, 2);
        run("srl_after_flush", 3'b001, 32'h0000_00F0, 5'd4, 32'h0000_000F, 2, 0);
        flush_test("flush_fin", 3'b000, 32'h0000_0003, 5'd1, 1);

        // Flush beats a simultaneous start in IDLE.
        op = 3'b000; data_in = 32'h1; shift_amount = 5'd1; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_ready", {63'd0, ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("flush_start_nodone", {63'd0, done}, 64'd0);

        run("busy_start", 3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 6, 2);
        @(posedge clk);
        @(negedge clk);
        check("busy_noqueue_done",  {63'd0, done}, 64'd0);
        check("busy_noqueue_ready", {63'd0, ready}, 64'd1);

        issue(3'b000, 32'h0000_0001, 5'd31);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data",  {32'd0, data_out}, 64'd0);
        check("midrst_done",  {63'd0, done}, 64'd0);
        check("midrst_ready", {63'd0, ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        last_out = 32'd0;
        @(negedge clk);
        run("rol4_after_rst", 3'b011, 32'h1234_5678, 5'd4, 32'h2345_6781, 2, 0);

        // Build without coarse bypass: 31 bits in 3-bit steps.
        op = 3'b000; data_in = 32'h0000_0001; shift_amount = 5'd31; start_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        edges = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (done_c === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("nocoarse_done",   {63'd0, seen}, 64'd1);
        check("nocoarse_cycles", 64'(edges), 64'd11);
        check("nocoarse_data",   {32'd0, data_out_c}, 64'h0000_0000_8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
